// File: rtl/alu_reg_n.sv
// ---------------------------------------------------------------------------
// alu_reg_n -- registered ALU with start/busy/done handshake.
//
// Single-cycle operations write the result register on the accepting edge and
// pulse done. func=110 runs a WIDTH-cycle shift-add multiplier while busy is
// high. use_reg selects the low half of the current result as operand B, which
// gives an accumulate mode.
//
// Ports:
//   clk      in   1         system clock, rising edge
//   reset_n  in   1         asynchronous active-low reset
//   A        in   WIDTH     operand A
//   B        in   WIDTH     operand B (external)
//   func     in   3         operation select, sampled with start
//   start    in   1         request, accepted only when not busy
//   use_reg  in   1         1 = operand B is result[WIDTH-1:0]
//   result   out  2*WIDTH   registered result
//   busy     out  1         multiply in progress
//   done     out  1         one-cycle pulse after result is written
// ---------------------------------------------------------------------------
module alu_reg_n #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         func,
  input  logic               start,
  input  logic               use_reg,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  // Shift amounts at or beyond the result width clear the result.
  localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH + 1)'(RW);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state,   w_state_nx;
  logic [RW-1:0]    r_result,  w_result_nx;
  logic             r_done,    w_done_nx;
  logic [RW-1:0]    r_mcand,   w_mcand_nx;
  logic [WIDTH-1:0] r_mplier,  w_mplier_nx;
  logic [RW-1:0]    r_partial, w_partial_nx;
  logic [CW-1:0]    r_count,   w_count_nx;

  logic [WIDTH-1:0] w_bop;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [RW-1:0]    w_shl;
  logic [RW-1:0]    w_addend;
  logic [RW-1:0]    w_partial_sum;

  // Datapath shared by the single-cycle operations.
  assign w_bop  = use_reg ? r_result[WIDTH-1:0] : B;
  assign w_inc  = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
  assign w_sum  = {1'b0, A} + {1'b0, w_bop};
  // The extra top bit of a (WIDTH+1)-bit subtract is exactly the borrow A<Bop.
  assign w_diff = {1'b0, A} - {1'b0, w_bop};
  assign w_shl  = {{WIDTH{1'b0}}, w_bop} << A;

  // One shift-add step: examine multiplier bit r_count.
  assign w_addend      = r_mplier[r_count] ? (r_mcand << r_count) : '0;
  assign w_partial_sum = r_partial + w_addend;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nx   = r_state;
    w_result_nx  = r_result;
    w_done_nx    = 1'b0;
    w_mcand_nx   = r_mcand;
    w_mplier_nx  = r_mplier;
    w_partial_nx = r_partial;
    w_count_nx   = r_count;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_done_nx = 1'b1;
          case (func)
            3'b000: w_result_nx = {{(WIDTH-1){1'b0}}, w_inc};
            3'b001: w_result_nx = {{(WIDTH-1){1'b0}}, w_sum};
            3'b010: w_result_nx = {{(WIDTH-1){1'b0}}, w_diff};
            3'b011: w_result_nx = {A | w_bop, A ^ w_bop};
            3'b100: w_result_nx = {{(RW-1){1'b0}}, |{A, w_bop}};
            3'b101: w_result_nx = ({1'b0, A} >= SHIFT_LIM) ? '0 : w_shl;
            3'b110: begin
              // Multiply: result is left alone until the product is ready.
              w_done_nx    = 1'b0;
              w_mcand_nx   = {{WIDTH{1'b0}}, A};
              w_mplier_nx  = w_bop;
              w_partial_nx = '0;
              w_count_nx   = '0;
              w_state_nx   = S_MUL;
            end
            3'b111: w_result_nx = r_result;
          endcase
        end
      end

      S_MUL: begin
        // start and operand inputs are deliberately ignored here.
        w_partial_nx = w_partial_sum;
        w_count_nx   = r_count + CW'(1);
        if (r_count == LAST_STEP) begin
          w_result_nx = w_partial_sum;
          w_done_nx   = 1'b1;
          w_count_nx  = '0;
          w_state_nx  = S_IDLE;
        end
      end

      default: w_state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others. All registers, including the
  // multiplier scratch registers, are reset so an aborted multiply leaves no
  // trace.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_partial <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_result  <= w_result_nx;
      r_done    <= w_done_nx;
      r_mcand   <= w_mcand_nx;
      r_mplier  <= w_mplier_nx;
      r_partial <= w_partial_nx;
      r_count   <= w_count_nx;
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = (r_state == S_MUL);

endmodule

// File: tb/tb_alu_reg_n.sv
// ---------------------------------------------------------------------------
// tb_alu_reg_n -- directed self-checking bench for alu_reg_n (WIDTH=4).
// A cycle-level arithmetic model tracks result/busy/done and is compared with
// the DUT on every falling edge; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_alu_reg_n;

  localparam int WIDTH = 4;
  localparam int MASK_W = (1 << WIDTH) - 1;
  localparam int MASK_R = (1 << (2 * WIDTH)) - 1;

  logic               clk;
  logic               reset_n;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [2:0]         func;
  logic               start;
  logic               use_reg;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               done;

  int n_checks = 0;
  int n_pass   = 0;

  alu_reg_n #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (a_in),
    .B       (b_in),
    .func    (func),
    .start   (start),
    .use_reg (use_reg),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_res  = 0;
  int m_done = 0;
  int m_cnt  = 0;   // remaining multiply cycles; busy while nonzero
  int m_prod = 0;

  function automatic int alu_model(input int f, input int a, input int b, input int cur);
    case (f)
      0: return a + 1;
      1: return a + b;
      2: return ((a - b) & MASK_W) | ((a < b) ? (1 << WIDTH) : 0);
      3: return ((a | b) << WIDTH) | (a ^ b);
      4: return ((a | b) != 0) ? 1 : 0;
      5: return (a >= 2 * WIDTH) ? 0 : ((b << a) & MASK_R);
      default: return cur;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int bop;
    if (!reset_n) begin
      m_res = 0; m_done = 0; m_cnt = 0; m_prod = 0;
    end else begin
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_res  = m_prod;
          m_done = 1;
        end
      end else if (start) begin
        bop = use_reg ? (m_res & MASK_W) : int'(b_in);
        if (func == 3'b110) begin
          m_prod = int'(a_in) * bop;
          m_cnt  = WIDTH;
        end else begin
          m_res  = alu_model(int'(func), int'(a_in), bop, m_res);
          m_done = 1;
        end
      end
    end
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin
    check("model_result", int'(result), m_res);
    check("model_busy",   int'(busy),   (m_cnt > 0) ? 1 : 0);
    check("model_done",   int'(done),   m_done);
  end

  task automatic op(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b,
                    input logic ur);
    @(negedge clk);
    func = f; a_in = a; b_in = b; use_reg = ur; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; a_in = '0; b_in = '0; func = '0; start = 1'b0; use_reg = 1'b0;

    // 1. Reset, release, idle.
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_result", int'(result), 0);
      check("idle_busy",   int'(busy),   0);
      check("idle_done",   int'(done),   0);
    end

    // 2. Add 9+8.
    op(3'b001, 4'd9, 4'd8, 1'b0);
    check("add_result", int'(result), 'h11);
    check("add_done",   int'(done),   1);
    check("add_busy",   int'(busy),   0);
    @(negedge clk);
    check("add_done_drop", int'(done), 0);

    // Async reset between edges clears immediately.
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_result", int'(result), 0);
    check("async_rst_busy",   int'(busy),   0);
    check("async_rst_done",   int'(done),   0);
    @(negedge clk);
    reset_n = 1'b1;

    // 3. 15*15 with an ignored start in the 2nd busy cycle.
    @(negedge clk);
    func = 3'b110; a_in = 4'd15; b_in = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mul_busy1", int'(busy), 1);
    @(negedge clk);
    a_in = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mul_busy3", int'(busy), 1);
    @(negedge clk);
    check("mul_busy4", int'(busy), 1);
    check("mul_not_yet", int'(result), 'h11 & 0);
    @(negedge clk);
    check("mul_result", int'(result), 'hE1);
    check("mul_done",   int'(done),   1);
    check("mul_busy_end", int'(busy), 0);
    repeat (2) begin
      @(negedge clk);
      check("mul_no_extra_done", int'(done), 0);
      check("mul_hold_result", int'(result), 'hE1);
    end

    // 3b. start held across the edge that clears busy: accepted one edge later.
    @(negedge clk);
    func = 3'b110; a_in = 4'd3; b_in = 4'd2; start = 1'b1;
    @(negedge clk);
    func = 3'b001; a_in = 4'd1; b_in = 4'd1;
    repeat (3) @(negedge clk);
    check("hold_busy4", int'(busy), 1);
    @(negedge clk);
    check("hold_mul_result", int'(result), 'h06);
    check("hold_mul_done",   int'(done),   1);
    @(negedge clk);
    start = 1'b0;
    check("hold_next_result", int'(result), 'h02);
    check("hold_next_done",   int'(done),   1);

    // 4. Accumulate, start held for three edges.
    @(negedge clk);
    func = 3'b001; a_in = 4'd5; b_in = 4'd0; use_reg = 1'b0; start = 1'b1;
    @(negedge clk);
    check("acc_load", int'(result), 'h05);
    a_in = 4'd3; use_reg = 1'b1;
    @(negedge clk);
    check("acc_1", int'(result), 'h08);
    check("acc_1_done", int'(done), 1);
    @(negedge clk);
    start = 1'b0; use_reg = 1'b0;
    check("acc_2", int'(result), 'h0B);
    check("acc_2_done", int'(done), 1);

    // Multiply with use_reg: 2 * 0xB, bounded wait for done.
    op(3'b110, 4'd2, 4'd0, 1'b1);
    for (int i = 0; i < 12 && !done; i++) @(negedge clk);
    check("mul_ur_done",   int'(done),   1);
    check("mul_ur_result", int'(result), 'h16);

    // 5. Subtract, shift, reduce, logic, hold.
    op(3'b010, 4'd3, 4'd5, 1'b0);
    check("sub_borrow", int'(result), 'h1E);
    op(3'b101, 4'd3, 4'hF, 1'b0);
    check("shl_3", int'(result), 'h78);
    op(3'b101, 4'd8, 4'hF, 1'b0);
    check("shl_8", int'(result), 'h00);
    op(3'b100, 4'd0, 4'd0, 1'b0);
    check("or_reduce_0", int'(result), 'h00);
    op(3'b011, 4'hA, 4'h6, 1'b0);
    check("or_xor", int'(result), 'hEC);
    op(3'b111, 4'h1, 4'h2, 1'b0);
    check("nop_hold", int'(result), 'hEC);
    check("nop_done", int'(done),   1);

    // 6. Reset during the 2nd busy cycle of 7*3.
    @(negedge clk);
    func = 3'b110; a_in = 4'd7; b_in = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy1", int'(busy), 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_result", int'(result), 0);
    check("abort_busy",   int'(busy),   0);
    check("abort_done",   int'(done),   0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
    end
    op(3'b000, 4'hF, 4'd0, 1'b0);
    check("inc_carry", int'(result), 'h10);
    check("inc_done",  int'(done),   1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_reg_n.md
Name: alu_reg_n

Overview:
- Parametrised, registered successor to the lab combinational ALU.
- Operands are WIDTH bits; the result register is 2*WIDTH bits.
- Adds a start/busy/done handshake, a multi-cycle shift-add multiplier, and an accumulate mode that feeds the low half of the result back as operand B.
- Sits between the switch/key input logic and the HEX/LEDR display decoders of the lab top level.

Parameters:
- WIDTH, 4, operand width in bits; result width is 2*WIDTH; WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B (external).
- func  input  3  operation select, sampled with start.
- start  input  1  request; accepted on a rising edge only when busy=0.
- use_reg  input  1  sampled with start; 1 = operand B is result[WIDTH-1:0] instead of port B.
- result  output  2*WIDTH  registered result.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse; high in the cycle after result is written.

Behaviour:
- Reset (async, reset_n=0): result=0, busy=0, done=0, FSM=IDLE, internal operand/counter registers=0. Takes effect immediately regardless of clk.
- FSM states: IDLE, MUL.
- In IDLE, on an edge with start=1, A and the selected B operand (Bop) are captured.
- Single-cycle operations (all except 110) write result on the accepting edge, set done=1 for exactly one cycle, and stay in IDLE.
- func codes (results zero-extended to 2*WIDTH unless stated):
  - 000: A+1; carry out in bit WIDTH.
  - 001: A+Bop; carry out in bit WIDTH.
  - 010: A-Bop mod 2^WIDTH in the low bits; bit WIDTH = 1 iff A<Bop (borrow); upper bits 0.
  - 011: {A|Bop, A^Bop}.
  - 100: bit0 = |{A,Bop}; all other bits 0.
  - 101: Bop logically shifted left by A within 2*WIDTH bits; result 0 if A >= 2*WIDTH.
  - 110: A*Bop, unsigned, multi-cycle; see below.
  - 111: result unchanged; done still pulses.
- Multiply (110):
  - Accepting edge: multiplicand=A, multiplier=Bop, partial=0, counter=0, busy=1, FSM=MUL. result is not changed.
  - Each MUL edge: if multiplier bit[counter]=1, add multiplicand<<counter to partial; then counter+1.
  - On the WIDTH-th MUL edge: result=final product, busy=0, done=1 for one cycle, FSM=IDLE.
  - Latency: start accepted at edge k; result valid after edge k+WIDTH; busy high for exactly WIDTH cycles.
- start with busy=1: ignored, not queued. Changes to A/B/func/use_reg during MUL have no effect.
- start held high in IDLE: a new operation is accepted every edge (back-to-back). done stays high when consecutive single-cycle operations complete.
- After a multiply, a start on the same edge that clears busy is not accepted. The earliest accept is the following edge.
- use_reg with func=110: Bop is the result value present at the accepting edge.
- Reset mid-multiply: operation aborted, no done pulse; after release the block is IDLE and the next start is accepted normally.
- Undefined or X func is not possible (3-bit full decode); no default hold beyond 111.

Test Plan (WIDTH=4):
1. Assert reset_n=0 asynchronously between edges -> result=0x00, busy=0, done=0 immediately. Release, idle 3 cycles -> all outputs still 0.
2. func=001, A=9, B=8, start for one cycle -> result=0x11 after that edge. done=1 for exactly one cycle; busy stays 0.
3. func=110, A=15, B=15, start -> busy=1 for 4 cycles, result=0xE1 after the 4th edge, single done pulse. A second start with A=2 at cycle 2 is ignored: result is not 0x1E, and no extra done pulse occurs.
4. Accumulate: load result=0x05 (func=001, A=5, B=0). Then func=001, A=3, use_reg=1, start twice -> result 0x08, then 0x0B.
5. Subtract and shift:
   - func=010, A=3, B=5 -> 0x1E.
   - func=101, A=3, B=0xF -> 0x78.
   - func=101, A=8 -> 0x00.
   - func=100, A=0, B=0 -> 0x00.
   - func=011, A=0xA, B=0x6 -> 0xEC.
6. Reset mid-operation: start multiply A=7, B=3, drive reset_n low in the 2nd busy cycle -> result=0, busy=0, no done pulse. After release, func=000, A=0xF -> result=0x10.
